// File: rtl/mc_irq_controller.sv
// Multicycle MIPS control FSM with a vectored, fixed-priority interrupt unit, edge-triggered NMI and ERET.
// Optional feature: define MCTRL_JUMP_EN to decode opcode 000010 as a jump (JUMP becomes a boundary state).
module mc_irq_controller #(
    parameter int unsigned NUM_IRQ = 4,
    parameter logic [5:0]  OP_ERET = 6'b010000,
    localparam int unsigned VEC_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               nmi,
    output logic               iord,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               ir_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [2:0]         pc_src,
    output logic               pc_en,
    output logic               epc_write,
    output logic [VEC_W-1:0]   vec_id,
    output logic               nmi_taken,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_isr,
    output logic [3:0]         state
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MCTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADR    = 4'd2,
        MEMRD     = 4'd3,
        MEMWB     = 4'd4,
        MEMWR     = 4'd5,
        EXEC      = 4'd6,
        RTEND     = 4'd7,
        BEQ       = 4'd8,
        JUMP      = 4'd9,
        IRQ_ENTRY = 4'd10,
        NMI_ENTRY = 4'd11,
        ERET      = 4'd12
    } state_t;

    state_t             state_q, state_d;
    logic               nmi_q;
    logic               nmi_pending_q, nmi_pending_d;
    logic               in_isr_q, in_isr_d;
    logic [VEC_W-1:0]   vec_id_q, vec_id_d;
    logic [NUM_IRQ-1:0] irq_pend;
    logic [VEC_W-1:0]   irq_sel;
    logic               boundary;
    logic               pc_write, pc_write_cond;

    // Lowest-index unmasked request wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        irq_pend = irq & ~irq_mask;
        irq_sel  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_pend[i]) irq_sel = i[VEC_W-1:0];
        end
    end

    always_comb begin
        state_d  = FETCH;
        boundary = 1'b0;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW)        state_d = MEMADR;
                else if (op == OP_RTYPE)               state_d = EXEC;
                else if (op == OP_BEQ)                 state_d = BEQ;
`ifdef MCTRL_JUMP_EN
                else if (op == OP_J)                   state_d = JUMP;
`endif
                else if (op == OP_ERET && in_isr_q)    state_d = ERET;
                else                                   state_d = FETCH;
            end
            MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = RTEND;
            MEMWB, MEMWR, RTEND, BEQ: boundary = 1'b1;
`ifdef MCTRL_JUMP_EN
            JUMP:   boundary = 1'b1;
`endif
            default: state_d = FETCH;
        endcase
        // Interrupts are only taken at instruction boundaries; NMI outranks maskable lines.
        if (boundary) begin
            if (nmi_pending_q)                state_d = NMI_ENTRY;
            else if ((|irq_pend) && !in_isr_q) state_d = IRQ_ENTRY;
            else                              state_d = FETCH;
        end
    end

    // A fresh NMI edge in the entry cycle survives the clear so it is not lost.
    always_comb begin
        nmi_pending_d = (nmi & ~nmi_q) | (nmi_pending_q & (state_d != NMI_ENTRY));
        in_isr_d      = in_isr_q;
        if (state_d == IRQ_ENTRY || state_d == NMI_ENTRY) in_isr_d = 1'b1;
        else if (state_d == ERET)                         in_isr_d = 1'b0;
        vec_id_d      = (state_d == IRQ_ENTRY) ? irq_sel : vec_id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            nmi_q         <= 1'b0;
            nmi_pending_q <= 1'b0;
            in_isr_q      <= 1'b0;
            vec_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            nmi_q         <= nmi;
            nmi_pending_q <= nmi_pending_d;
            in_isr_q      <= in_isr_d;
            vec_id_q      <= vec_id_d;
        end
    end

    always_comb begin
        iord          = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 3'b000;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        epc_write     = 1'b0;
        nmi_taken     = 1'b0;
        irq_ack       = '0;
        case (state_q)
            FETCH:  begin ir_write = 1'b1; pc_write = 1'b1; alu_src_b = 2'b01; end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            MEMRD:  iord = 1'b1;
            MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; end
            MEMWR:  begin mem_write = 1'b1; iord = 1'b1; end
            EXEC:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
            RTEND:  begin reg_write = 1'b1; reg_dst = 1'b1; end
            BEQ:    begin alu_src_a = 1'b1; alu_op = 2'b01; pc_write_cond = 1'b1; pc_src = 3'b001; end
`ifdef MCTRL_JUMP_EN
            JUMP:   begin pc_write = 1'b1; pc_src = 3'b010; end
`endif
            IRQ_ENTRY: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = 3'b011;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    irq_ack[i] = (vec_id_q == i[VEC_W-1:0]);
                end
            end
            NMI_ENTRY: begin epc_write = 1'b1; pc_write = 1'b1; pc_src = 3'b011; nmi_taken = 1'b1; end
            ERET:   begin pc_write = 1'b1; pc_src = 3'b100; end
            default: ;
        endcase
    end

    assign pc_en  = pc_write | (pc_write_cond & zero);
    assign vec_id = vec_id_q;
    assign in_isr = in_isr_q;
    assign state  = state_q;

endmodule

// File: tb/tb_mc_irq_controller.sv
// Directed bench for mc_irq_controller: instruction sequencing, IRQ/NMI entry, ERET and reset.
module tb_mc_irq_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic [3:0] irq;
    logic [3:0] irq_mask;
    logic       nmi;
    logic       iord, mem_write, mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic [2:0] pc_src;
    logic       pc_en, epc_write, nmi_taken, in_isr;
    logic [1:0] vec_id;
    logic [3:0] irq_ack;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    mc_irq_controller dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .irq(irq), .irq_mask(irq_mask), .nmi(nmi),
        .iord(iord), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en), .epc_write(epc_write), .vec_id(vec_id),
        .nmi_taken(nmi_taken), .irq_ack(irq_ack), .in_isr(in_isr), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; op = 6'b000000; zero = 1'b0; irq = 4'b0000; irq_mask = 4'b0000; nmi = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_in_isr", 32'(in_isr), 32'd0);
        chk("rst_vec_id", 32'(vec_id), 32'd0);
        chk("rst_ir_write", 32'(ir_write), 32'd1);
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        chk("rst_alu_src_b", 32'(alu_src_b), 32'd1);
        chk("rst_epc_write", 32'(epc_write), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);

        // lw: 0,1,2,3,4,0
        reset = 1'b0; op = 6'b100011;
        step(); chk("lw_decode", 32'(state), 32'd1);
        chk("lw_decode_pc_en", 32'(pc_en), 32'd0);
        chk("lw_decode_srcb", 32'(alu_src_b), 32'd3);
        step(); chk("lw_memadr", 32'(state), 32'd2);
        chk("lw_memadr_srca", 32'(alu_src_a), 32'd1);
        chk("lw_memadr_srcb", 32'(alu_src_b), 32'd2);
        step(); chk("lw_memrd", 32'(state), 32'd3);
        chk("lw_memrd_iord", 32'(iord), 32'd1);
        step(); chk("lw_memwb", 32'(state), 32'd4);
        chk("lw_memwb_regw", 32'(reg_write), 32'd1);
        chk("lw_memwb_m2r", 32'(mem_to_reg), 32'd1);
        chk("lw_memwb_pc_en", 32'(pc_en), 32'd0);
        step(); chk("lw_fetch", 32'(state), 32'd0);
        chk("lw_fetch_pc_en", 32'(pc_en), 32'd1);

        // beq with zero=1 then zero=0
        op = 6'b000100; zero = 1'b1;
        step(); chk("beq_decode", 32'(state), 32'd1);
        step(); chk("beq_state", 32'(state), 32'd8);
        chk("beq_pc_en_z1", 32'(pc_en), 32'd1);
        chk("beq_pc_src", 32'(pc_src), 32'd1);
        chk("beq_alu_op", 32'(alu_op), 32'd1);
        zero = 1'b0; #1;
        chk("beq_pc_en_z0", 32'(pc_en), 32'd0);
        step(); chk("beq_fetch", 32'(state), 32'd0);

        // R-type with masked/unmasked lines pending: line 2 wins
        op = 6'b000000; irq = 4'b0110; irq_mask = 4'b0010;
        step(); chk("rt_decode", 32'(state), 32'd1);
        step(); chk("rt_exec", 32'(state), 32'd6);
        chk("rt_exec_alu_op", 32'(alu_op), 32'd2);
        step(); chk("rt_rtend", 32'(state), 32'd7);
        chk("rt_rtend_regdst", 32'(reg_dst), 32'd1);
        step(); chk("irq_entry", 32'(state), 32'd10);
        chk("irq_vec_id", 32'(vec_id), 32'd2);
        chk("irq_ack", 32'(irq_ack), 32'h4);
        chk("irq_epc_write", 32'(epc_write), 32'd1);
        chk("irq_pc_src", 32'(pc_src), 32'd3);
        chk("irq_in_isr", 32'(in_isr), 32'd1);
        chk("irq_pc_en", 32'(pc_en), 32'd1);

        // unmasking irq[1] while in_isr=1 must not nest
        irq = 4'b0010; irq_mask = 4'b0000;
        step(); chk("isr_fetch", 32'(state), 32'd0);
        chk("isr_ack_pulse", 32'(irq_ack), 32'd0);
        chk("isr_in_isr", 32'(in_isr), 32'd1);
        step(); step(); step();
        chk("isr_rtend", 32'(state), 32'd7);
        step(); chk("isr_no_nest", 32'(state), 32'd0);

        // ERET with in_isr=1
        op = 6'b010000; irq = 4'b0000;
        step(); chk("eret_decode", 32'(state), 32'd1);
        step(); chk("eret_state", 32'(state), 32'd12);
        chk("eret_pc_src", 32'(pc_src), 32'd4);
        chk("eret_pc_en", 32'(pc_en), 32'd1);
        chk("eret_in_isr", 32'(in_isr), 32'd0);
        step(); chk("eret_fetch", 32'(state), 32'd0);
        // same opcode with in_isr=0 is unknown
        step(); chk("eret2_decode", 32'(state), 32'd1);
        chk("eret2_pc_src", 32'(pc_src), 32'd0);
        step(); chk("eret2_fetch", 32'(state), 32'd0);
        chk("eret2_in_isr", 32'(in_isr), 32'd0);

        // sw with NMI edge and irq[0] at the same boundary
        op = 6'b101011;
        step(); chk("sw_decode", 32'(state), 32'd1);
        step(); chk("sw_memadr", 32'(state), 32'd2);
        nmi = 1'b1; irq = 4'b0001;
        step(); chk("sw_memwr", 32'(state), 32'd5);
        chk("sw_mem_write", 32'(mem_write), 32'd1);
        chk("sw_iord", 32'(iord), 32'd1);
        step(); chk("nmi_entry", 32'(state), 32'd11);
        chk("nmi_taken", 32'(nmi_taken), 32'd1);
        chk("nmi_epc_write", 32'(epc_write), 32'd1);
        chk("nmi_pc_src", 32'(pc_src), 32'd3);
        chk("nmi_irq_ack", 32'(irq_ack), 32'd0);
        chk("nmi_in_isr", 32'(in_isr), 32'd1);
        nmi = 1'b0;
        step(); chk("nmi_fetch", 32'(state), 32'd0);
        op = 6'b000100; zero = 1'b0;
        step(); step();
        chk("nmi_beq", 32'(state), 32'd8);
        step(); chk("nmi_irq0_blocked", 32'(state), 32'd0);
        irq = 4'b0000;

        // jump opcode
        op = 6'b000010;
        step(); chk("j_decode", 32'(state), 32'd1);
        step();
`ifdef MCTRL_JUMP_EN
        chk("j_state", 32'(state), 32'd9);
        chk("j_pc_src", 32'(pc_src), 32'd2);
        step(); chk("j_fetch", 32'(state), 32'd0);
`else
        chk("j_unknown", 32'(state), 32'd0);
        chk("j_pc_src", 32'(pc_src), 32'd0);
`endif

        // reset mid-MEMRD
        op = 6'b100011;
        step(); step(); step();
        chk("rst_mid_memrd", 32'(state), 32'd3);
        reset = 1'b1;
        step(); chk("rst_mid_state", 32'(state), 32'd0);
        chk("rst_mid_in_isr", 32'(in_isr), 32'd0);
        chk("rst_mid_vec_id", 32'(vec_id), 32'd0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
